textlcd_bus_driver: RTL and testbench

- Sits directly downstream of the mode display blocks (clock, time-set, etc.). Consumes their per-cycle RW/RS/DATA word stream and drives the HD44780-compatible character LCD bus.
- After reset it runs the LCD power-up and initialisation sequence, then raises EN. The mode blocks start their screen-refresh counters only while EN is high.
- In run state it forwards each write word to the panel and generates the LCD_E strobe.
- CLK is the 1 kHz system tick (1 cycle = 1 ms).

---
 rtl/textlcd_bus_driver_if.sv | 22 ++
 rtl/textlcd_bus_driver.sv | 136 +++++++++++++
 tb/tb_textlcd_bus_driver.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/textlcd_bus_driver_if.sv
// Word stream from the mode display stage and the HD44780 bus driven toward the panel.
interface textlcd_bus_driver_if;
  logic       RW_IN;
  logic       RS_IN;
  logic [7:0] DATA_IN;
  logic       REINIT;
  logic       EN;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  modport master (
    output RW_IN, RS_IN, DATA_IN, REINIT,
    input  EN, LCD_E, LCD_RS, LCD_RW, LCD_DATA
  );

  modport slave (
    input  RW_IN, RS_IN, DATA_IN, REINIT,
    output EN, LCD_E, LCD_RS, LCD_RW, LCD_DATA
  );
endinterface

// File: rtl/textlcd_bus_driver.sv
// HD44780 character LCD bus driver: power-up wait, init command burst, then
// forwards mode-stage write words with a half-cycle E strobe.
module textlcd_bus_driver #(
  parameter int PWRUP_CYC = 20,
  parameter int CLR_CYC   = 2
) (
  input logic                 CLK,
  input logic                 RESET,
  textlcd_bus_driver_if.slave bus
);

  localparam int MAXC = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {S_PWR, S_INIT, S_CLRW, S_RUN} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_idx, w_idx;
  logic          r_en, w_en;
  logic          r_rs, w_rs;
  logic          r_rw, w_rw;
  logic [7:0]    r_data, w_data;
  logic          w_launch;
  logic          r_tog_p, r_tog_n, r_tog_q;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd3:    init_cmd = 8'h0C;
      3'd4:    init_cmd = 8'h06;
      3'd5:    init_cmd = 8'h01;
      default: init_cmd = 8'h38;
    endcase
  endfunction

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_en    = r_en;
    w_rs    = r_rs;
    w_rw    = 1'b1;
    w_data  = r_data;
    unique case (r_state)
      S_PWR: begin
        if (r_cnt == CW'(PWRUP_CYC - 1)) begin
          w_state = S_INIT;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_INIT: begin
        // REINIT held parks the sequence at index 0 with the bus idle
        if (bus.REINIT) begin
          w_idx = 3'd0;
        end else begin
          w_rs   = 1'b0;
          w_rw   = 1'b0;
          w_data = init_cmd(r_idx);
          if (r_idx == 3'd5) begin
            w_state = S_CLRW;
            w_idx   = 3'd0;
            w_cnt   = '0;
          end else begin
            w_idx = r_idx + 3'd1;
          end
        end
      end
      S_CLRW: begin
        if (bus.REINIT) begin
          w_state = S_INIT;
          w_idx   = 3'd0;
          w_cnt   = '0;
        end else if (r_cnt == CW'(CLR_CYC - 1)) begin
          w_state = S_RUN;
          w_en    = 1'b1;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (bus.REINIT) begin
          w_state = S_INIT;
          w_idx   = 3'd0;
          w_en    = 1'b0;
        end else begin
          w_rs   = bus.RS_IN;
          w_rw   = bus.RW_IN;
          w_data = bus.DATA_IN;
        end
      end
    endcase
  end

  assign w_launch = ~w_rw;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_PWR;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_rw    <= 1'b1;
      r_data  <= 8'h00;
      r_tog_p <= 1'b0;
      r_tog_q <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_en    <= w_en;
      r_rs    <= w_rs;
      r_rw    <= w_rw;
      r_data  <= w_data;
      if (w_launch) r_tog_p <= ~r_tog_p;
      r_tog_q <= r_tog_n;
    end
  end

  // E rises when the negedge copy picks up a launch toggle and falls when the
  // next posedge catches up, so back-to-back words each get a clean pulse.
  always_ff @(negedge CLK or negedge RESET) begin
    if (!RESET) r_tog_n <= 1'b0;
    else        r_tog_n <= r_tog_p;
  end

  assign bus.EN       = r_en;
  assign bus.LCD_E    = r_tog_n ^ r_tog_q;
  assign bus.LCD_RS   = r_rs;
  assign bus.LCD_RW   = r_rw;
  assign bus.LCD_DATA = r_data;

endmodule

// File: tb/tb_textlcd_bus_driver.sv
// Scoreboard bench for textlcd_bus_driver: every E strobe is matched against queued words.
module tb_textlcd_bus_driver;
  logic CLK = 1'b0;
  logic RESET;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_stb = 0;
  logic [8:0] sb[$];

  always #5 CLK = ~CLK;

  textlcd_bus_driver_if bus();

  textlcd_bus_driver #(.PWRUP_CYC(20), .CLR_CYC(2)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every rising E must land on a negedge and carry the next expected word.
  always @(posedge bus.LCD_E) begin
    logic [8:0] e;
    n_stb++;
    chk("e_phase", 32'(CLK), 0);
    if (sb.size() == 0) begin
      chk("unexp_strobe", {23'd1, bus.LCD_RS, bus.LCD_DATA}, 0);
    end else begin
      e = sb.pop_front();
      chk("strobe_word", {bus.LCD_RW, bus.LCD_RS, bus.LCD_DATA}, {1'b0, e});
    end
  end

  always @(posedge CLK) begin
    #1;
    chk("e_low_after_edge", 32'(bus.LCD_E), 0);
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic push_init();
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h06});
    sb.push_back({1'b0, 8'h01});
  endtask

  // Mode stage keeps pushing its line-1 command while EN=0; none of it may reach the bus.
  task automatic run_init(input string tag, input int w);
    int k;
    int base;
    k = 0;
    base = n_stb;
    push_init();
    bus.RW_IN = 1'b0;
    bus.RS_IN = 1'b0;
    bus.DATA_IN = 8'h80;
    while (!bus.EN && k < w + 20) begin
      @(posedge CLK); #1;
      k++;
      if (w > 0 && k == w) chk({tag, "_pwrup_quiet"}, n_stb - base, 0);
      if (k == w + 7)      chk({tag, "_init_strobes"}, n_stb - base, 6);
    end
    bus.RW_IN = 1'b1;
    chk({tag, "_en_cycle"}, k, w + 8);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    sb.push_back({rs, d});
    bus.RW_IN = 1'b0;
    bus.RS_IN = rs;
    bus.DATA_IN = d;
    @(posedge CLK); #1;
    chk("run_bus", {bus.LCD_RW, bus.LCD_RS, bus.LCD_DATA}, {1'b0, rs, d});
    @(negedge CLK); #1;
    chk("run_e_high", 32'(bus.LCD_E), 1);
  endtask

  initial begin
    int base;
    RESET = 1'b1;
    bus.RW_IN = 1'b0;
    bus.RS_IN = 1'b0;
    bus.DATA_IN = 8'h80;
    bus.REINIT = 1'b0;
    #2 RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_state", {bus.EN, bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA}, {4'b0001, 8'h00});
    @(negedge CLK);
    RESET = 1'b1;
    run_init("pwrup", 20);

    send(1'b1, 8'h41);
    bus.RW_IN = 1'b1;
    @(posedge CLK); #1;
    chk("after_word_rw", 32'(bus.LCD_RW), 1);
    send(1'b1, 8'h48);
    send(1'b1, 8'h49);
    send(1'b0, 8'hC0);
    for (int i = 0; i < 4; i++) send(1'($urandom_range(0, 1)), 8'($urandom));
    bus.RW_IN = 1'b1;

    bus.RS_IN = 1'b0;
    bus.DATA_IN = 8'h02;
    @(posedge CLK); #1;
    chk("idle_word_bus", {bus.LCD_RW, bus.LCD_DATA}, {1'b1, 8'h02});
    @(negedge CLK); #1;
    chk("idle_word_no_e", 32'(bus.LCD_E), 0);

    bus.REINIT = 1'b1;
    @(posedge CLK); #1;
    chk("reinit_en_fall", 32'(bus.EN), 0);
    chk("reinit_bus_idle", 32'(bus.LCD_RW), 1);
    bus.REINIT = 1'b0;
    run_init("reinit", 0);
    send(1'b1, 8'h5A);
    bus.RW_IN = 1'b1;

    base = n_stb;
    bus.REINIT = 1'b1;
    bus.RW_IN = 1'b0;
    bus.DATA_IN = 8'h80;
    repeat (4) begin @(posedge CLK); #1; end
    chk("hold_en", 32'(bus.EN), 0);
    chk("hold_rw", 32'(bus.LCD_RW), 1);
    chk("hold_no_strobe", n_stb - base, 0);
    bus.REINIT = 1'b0;
    run_init("reinit_hold", 0);

    sb.push_back({1'b1, 8'h4F});
    bus.RW_IN = 1'b0;
    bus.RS_IN = 1'b1;
    bus.DATA_IN = 8'h4F;
    @(posedge CLK); #1;
    bus.RW_IN = 1'b1;
    @(negedge CLK); #1;
    chk("pre_reset_e", 32'(bus.LCD_E), 1);
    RESET = 1'b0;
    #1;
    chk("reset_e_async", 32'(bus.LCD_E), 0);
    chk("reset_mid_state", {bus.EN, bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA}, {4'b0001, 8'h00});
    @(negedge CLK);
    RESET = 1'b1;
    run_init("rst_again", 20);

    repeat (3) @(posedge CLK);
    #2;
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
